// File: rtl/irrig_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | irrig_pkg: shared mode codes, sequencer states, fault bit indices |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
package irrig_pkg;

  // Mode codes match the mode classifier's output encoding
  localparam logic [1:0] NADA = 2'b00;
  localparam logic [1:0] ASP  = 2'b10;
  localparam logic [1:0] GOT  = 2'b01;

  typedef enum logic [2:0] {
    IDLE = 3'b000,
    OPEN = 3'b001,
    RUN  = 3'b010,
    STOP = 3'b011
  } state_t;

  localparam int FLT_DRY = 0;
  localparam int FLT_TMO = 1;

endpackage
`default_nettype wire

// File: rtl/irrig_dwell_counter.sv
`default_nettype none
// +------------------------------------------------------------------+
// | irrig_dwell_counter: CW-bit saturating dwell counter, sync clear  |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module irrig_dwell_counter #(
  parameter int CW = 8
) (
  input  logic          CLK,
  input  logic          resetN,
  input  logic          clr,
  output logic [CW-1:0] cnt
);

  logic [CW-1:0] r_cnt;

  always_ff @(posedge CLK or posedge resetN) begin
    if (resetN)
      r_cnt <= '0;
    else if (clr)
      r_cnt <= '0;
    else if (r_cnt != {CW{1'b1}})
      r_cnt <= r_cnt + 1'b1;
  end

  assign cnt = r_cnt;

endmodule
`default_nettype wire

// File: rtl/irrigation_sequencer.sv
`default_nettype none
// +------------------------------------------------------------------+
// | irrigation_sequencer: valve/pump sequencing with settle, run and  |
// | drain intervals plus sticky dry-tank and timeout faults. Rev 1.0 |
// +------------------------------------------------------------------+
module irrigation_sequencer
  import irrig_pkg::*;
#(
  parameter int SETTLE_CYC  = 4,
  parameter int MIN_ON_CYC  = 8,
  parameter int MAX_RUN_CYC = 200,
  parameter int DRAIN_CYC   = 4,
  parameter int CW          = 8
) (
  input  logic       CLK,
  input  logic       resetN,
  input  logic [1:0] mode,
  input  logic       tank_low,
  output logic       valve_asp,
  output logic       valve_got,
  output logic       pump,
  output logic       busy,
  output logic [1:0] fault,
  output logic [2:0] state_out
);

  localparam logic [CW-1:0] c_settle_last = CW'(SETTLE_CYC - 1);
  localparam logic [CW-1:0] c_min_last    = CW'(MIN_ON_CYC - 1);
  localparam logic [CW-1:0] c_max_last    = CW'(MAX_RUN_CYC - 1);
  localparam logic [CW-1:0] c_drain_last  = CW'(DRAIN_CYC - 1);

  state_t        r_state;
  state_t        w_next;
  logic [1:0]    r_sel;
  logic [1:0]    r_fault;
  logic [1:0]    w_fault_set;
  logic [1:0]    w_fault_clr;
  logic [1:0]    w_mode;
  logic [CW-1:0] w_cnt;

  // Code 11 carries no zone and behaves exactly like 00
  assign w_mode = (mode == 2'b11) ? NADA : mode;

  irrig_dwell_counter #(.CW(CW)) u_dwell (
    .CLK    (CLK),
    .resetN (resetN),
    .clr    (w_next != r_state),
    .cnt    (w_cnt)
  );

  always_comb begin
    w_next      = r_state;
    w_fault_set = 2'b00;
    w_fault_clr = 2'b00;
    case (r_state)
      IDLE: begin
        if (w_mode == NADA) begin
          w_fault_clr[FLT_TMO] = 1'b1;
          w_fault_clr[FLT_DRY] = ~tank_low;
        end else if (!tank_low && r_fault == 2'b00) begin
          w_next = OPEN;
        end
      end
      OPEN: begin
        if (tank_low) begin
          w_next               = STOP;
          w_fault_set[FLT_DRY] = 1'b1;
        end else if (w_mode != r_sel) begin
          w_next = STOP;
        end else if (w_cnt == c_settle_last) begin
          w_next = RUN;
        end
      end
      RUN: begin
        if (tank_low) begin
          w_next               = STOP;
          w_fault_set[FLT_DRY] = 1'b1;
        end else if (w_cnt == c_max_last) begin
          w_next               = STOP;
          w_fault_set[FLT_TMO] = 1'b1;
        end else if (w_mode != r_sel && w_cnt >= c_min_last) begin
          w_next = STOP;
        end
      end
      STOP: begin
        if (w_cnt == c_drain_last)
          w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge resetN) begin
    if (resetN) begin
      r_state <= IDLE;
      r_sel   <= NADA;
      r_fault <= 2'b00;
    end else begin
      r_state <= w_next;
      r_fault <= (r_fault & ~w_fault_clr) | w_fault_set;
      if (r_state == IDLE && w_next == OPEN)
        r_sel <= w_mode;
    end
  end

  assign busy      = (r_state != IDLE);
  assign pump      = (r_state == RUN);
  assign valve_asp = (r_sel == ASP) && (r_state inside {OPEN, RUN, STOP});
  assign valve_got = (r_sel == GOT) && (r_state inside {OPEN, RUN, STOP});
  assign fault     = r_fault;
  assign state_out = r_state;

endmodule
`default_nettype wire

// File: doc/irrigation_sequencer.md
# irrigation_sequencer

Sequences the irrigation hardware behind the mode classifier: it takes the 2-bit mode code (none / sprinkler / drip) and drives the two zone valves and the single shared pump. Valves always open before the pump starts and close only after it stops. The pump is never on without exactly one valve open. It enforces settle, minimum-run, maximum-run and drain intervals, and latches dry-tank and timeout faults.

## Interface
- SETTLE_CYC, 4: cycles a valve is open before pump starts (≥1)
- MIN_ON_CYC, 8: minimum pump-on cycles before a mode change is honoured (≥1)
- MAX_RUN_CYC, 200: pump-on cycles after which run is forced to stop (≥ MIN_ON_CYC)
- DRAIN_CYC, 4: cycles valve stays open after pump stops (≥1)
- CW, 8: counter width; all cycle parameters ≤ 2^CW−1
- CLK  in  1  clock, rising edge
- resetN  in  1  reset, asynchronous, active-high
- mode  in  2  requested mode: 00 none, 10 sprinkler (ASP), 01 drip (GOT), 11 treated as 00
- tank_low  in  1  1 = reservoir empty, synchronous to CLK
- valve_asp  out  1  sprinkler valve open
- valve_got  out  1  drip valve open
- pump  out  1  pump on
- busy  out  1  1 in any state other than IDLE
- fault  out  2  sticky; bit0 dry-tank, bit1 run timeout
- state_out  out  3  current state code, for debug/display

## Operation
- States: IDLE=000, OPEN=001, RUN=010, STOP=011. Other codes go to IDLE on the next edge.
- Register sel[1:0] latches the zone (10 or 01) on the IDLE→OPEN transition. It is held until the next return to IDLE.
- A single counter cnt clears on every state change, increments every cycle while in the state, and saturates at 2^CW−1.
- IDLE: go to OPEN when all of these hold: mode ∈ {10,01}, tank_low=0, fault=00.
- IDLE, fault clearing: when mode=00, clear fault bit1. Also clear bit0 if tank_low=0.
- OPEN: go to STOP if tank_low=1 (set fault[0]) or mode≠sel. Otherwise go to RUN when cnt=SETTLE_CYC−1.
- RUN: priority is tank_low=1 → STOP and set fault[0]. Else cnt=MAX_RUN_CYC−1 → STOP and set fault[1]. Else mode≠sel and cnt≥MIN_ON_CYC−1 → STOP.
- STOP: go to IDLE when cnt=DRAIN_CYC−1. Mode and tank_low are ignored in STOP.
- Switching zones always passes STOP→IDLE→OPEN. Two valves are never open simultaneously.
- Outputs:
  - valve_asp = (sel=10) & state∈{OPEN,RUN,STOP}
  - valve_got likewise for sel=01
  - pump = (state=RUN)
  - busy = (state≠IDLE)
- Fault bits set in the same edge as the transition into STOP. A set and a clear of the same bit cannot coincide, because clears happen only in IDLE.

## Timing
- All outputs are registered or decoded from registers only. There is no combinational path from inputs to outputs.
- Reset values: state=IDLE, sel=00, cnt=0, fault=00. Therefore valve_asp=valve_got=pump=busy=0 and state_out=000.
- Reset mid-operation drops all outputs asynchronously. No drain sequence runs.
- Latency, mode 00→10 sampled at edge k:
  - busy and valve_asp high after edge k.
  - pump high after edge k+SETTLE_CYC.
- Stop latency, mode change in RUN at or after the minimum run:
  - pump low after the next edge.
  - valve low DRAIN_CYC edges later.
- Minimum IDLE dwell between runs is 1 cycle.
- Mode glitches inside MIN_ON are absorbed. Only the mode level present at the MIN_ON boundary or later causes a stop.

## Structure
- Shared package irrig_pkg holds:
  - mode codes NADA=2'b00, ASP=2'b10, GOT=2'b01, identical to the mode classifier's output;
  - state codes;
  - fault bit indices.
- One sub-module, irrig_dwell_counter: CW-bit saturating counter with sync clear and async reset.
- The FSM, sel register, fault register and output decode stay in irrigation_sequencer.

## Test plan
- Reset then mode=10 held: valve_asp rises 1 cycle after the sampling edge. Pump rises 4 cycles later. valve_got stays 0 throughout.
- In RUN, mode 10→01 at pump-on cycle 3: pump stays on until cycle 8, then STOP for 4 cycles and IDLE for 1. valve_got opens, and pump resumes 4 cycles later.
- tank_low=1 during RUN: pump off on the next edge and fault=01. After drain, stays IDLE even with mode=10. Setting mode=00 and tank_low=0 clears fault.
- Mode=01 held for 200 pump cycles: forced STOP and fault=10. No restart until mode=00 is seen in IDLE.
- Mode=11 or 00 from reset: stays IDLE with all outputs 0.
- Assert resetN in RUN: valve, pump and busy fall immediately. After release, state_out=000 and fault=00.
